riscv_decode_stage: RTL and testbench

Registered RV32I decode stage with an instruction queue and valid/ready handshakes on both sides. It sits between fetch and execute. It buffers up to IQ_DEPTH fetched instructions, decodes one per cycle into a registered control bundle, and supports pipeline flush. It also adds full immediate generation, register-index extraction, funct3/funct7 legality checks and load/store size decode.

---
 rtl/riscv_decode_pkg.sv | 105 ++++++++++
 rtl/riscv_decode_comb.sv | 141 ++++++++++++++
 rtl/riscv_decode_stage.sv | 143 ++++++++++++++
 tb/tb_riscv_decode_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg
//   Shared decode definitions for the RV32I decode stage: opcode constants,
//   ALU operation codes (including the M-extension ops), operand-select codes,
//   load/store size codes and the registered decode bundle type.
//   Used by riscv_decode_comb and riscv_decode_stage.
package riscv_decode_pkg;

    localparam int ALU_OP_WIDTH = 5;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // M ops occupy 16..23 so that {2'b10, funct3} maps directly onto them.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_XOR    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_AND    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_EQ     = 5'd10,
        ALU_NE     = 5'd11,
        ALU_LT     = 5'd12,
        ALU_GE     = 5'd13,
        ALU_LTU    = 5'd14,
        ALU_GEU    = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_A_RS1     = 2'd0,
        OP_A_CURR_PC = 2'd1,
        OP_A_ZERO    = 2'd2
    } op_a_sel_e;

    typedef enum logic [2:0] {
        OP_B_RS2  = 3'd0,
        OP_B_IMM  = 3'd1,
        OP_B_INCR = 3'd2
    } op_b_sel_e;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        op_a_sel_e   op_a_sel;
        op_b_sel_e   op_b_sel;
        alu_op_e     alu_op;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        gpr_we;
        logic        wb_src;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } decode_t;

    // Integer ALU op from funct3; alt selects SUB/SRA (instr[30]).
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// riscv_decode_comb
//   Purely combinational RV32I instruction decode into a decode_t bundle:
//   register indices, I/S/B/U/J immediate, operand selects, ALU op, memory
//   controls, control-flow class and legality.
//   Optional macro RV_M_EXT_EN: when defined, OP with funct7=0000001 decodes
//   to the M-extension ops; otherwise those encodings are illegal.
// Ports:
//   instr : 32-bit instruction word
//   dec   : decoded bundle
module riscv_decode_comb
    import riscv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // dec unassigned, which would otherwise infer a latch.
        dec          = '0;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.imm      = imm_i;
        dec.op_a_sel = OP_A_RS1;
        dec.op_b_sel = OP_B_IMM;
        dec.alu_op   = ALU_ADD;

        case (opcode)
            OPC_LOAD: begin
                dec.mem_req  = 1'b1;
                dec.gpr_we   = 1'b1;
                dec.wb_src   = 1'b1;
                dec.mem_size = funct3;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) dec.illegal = 1'b1;
            end
            OPC_STORE: begin
                dec.imm      = imm_s;
                dec.mem_req  = 1'b1;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                if (funct3 > 3'd2) dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.gpr_we = 1'b1;
                // Only shifts carry a funct7; for the rest instr[31:25] is immediate.
                dec.alu_op = alu_op_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1 && funct7 != 7'h00) dec.illegal = 1'b1;
                if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) dec.illegal = 1'b1;
            end
            OPC_OP: begin
                dec.op_b_sel = OP_B_RS2;
                dec.gpr_we   = 1'b1;
                if (funct7 == 7'h00)
                    dec.alu_op = alu_op_from_funct3(funct3, 1'b0);
                else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
                    dec.alu_op = alu_op_from_funct3(funct3, 1'b1);
`ifdef RV_M_EXT_EN
                else if (funct7 == 7'h01)
                    dec.alu_op = alu_op_e'({2'b10, funct3});
`endif
                else
                    dec.illegal = 1'b1;
            end
            OPC_LUI: begin
                dec.imm      = imm_u;
                dec.op_a_sel = OP_A_ZERO;
                dec.gpr_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm      = imm_u;
                dec.op_a_sel = OP_A_CURR_PC;
                dec.gpr_we   = 1'b1;
            end
            OPC_JAL: begin
                // The ALU produces the link value pc+4; the target uses imm.
                dec.imm      = imm_j;
                dec.op_a_sel = OP_A_CURR_PC;
                dec.op_b_sel = OP_B_INCR;
                dec.gpr_we   = 1'b1;
                dec.jal      = 1'b1;
            end
            OPC_JALR: begin
                dec.op_a_sel = OP_A_CURR_PC;
                dec.op_b_sel = OP_B_INCR;
                dec.gpr_we   = 1'b1;
                dec.jalr     = 1'b1;
                if (funct3 != 3'd0) dec.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm      = imm_b;
                dec.op_b_sel = OP_B_RS2;
                dec.branch   = 1'b1;
                case (funct3)
                    3'd0:    dec.alu_op = ALU_EQ;
                    3'd1:    dec.alu_op = ALU_NE;
                    3'd4:    dec.alu_op = ALU_LT;
                    3'd5:    dec.alu_op = ALU_GE;
                    3'd6:    dec.alu_op = ALU_LTU;
                    3'd7:    dec.alu_op = ALU_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                // FENCE: ordering is trivially satisfied in this pipeline.
            end
            OPC_SYSTEM: begin
                if (instr != INSTR_ECALL && instr != INSTR_EBREAK) dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) dec.illegal = 1'b1;

        // An illegal instruction must have no architectural side effects.
        if (dec.illegal) begin
            dec.mem_req = 1'b0;
            dec.mem_we  = 1'b0;
            dec.gpr_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//   Registered RV32I decode stage between fetch and execute. Fetched
//   instructions are buffered in an IQ_DEPTH-entry circular queue; the head is
//   decoded and loaded into the output register whenever that register is
//   empty or being consumed. flush_i empties queue and output at the next edge
//   and takes priority over push and pop.
//   Optional macro RV_M_EXT_EN enables M-extension decode (see riscv_decode_comb).
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       discard queued and output-stage instructions
//   in_valid_i/in_ready_o         fetch handshake; in_instr_i, in_pc_i payload
//   out_valid_o/out_ready_i       execute handshake
//   pc_o, rs1_o, rs2_o, rd_o, imm_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
//   mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o,
//   branch_o, jal_o, jalr_o, illegal_instr_o   registered decode bundle
module riscv_decode_stage #(
    parameter int XLEN         = 32,
    parameter int IQ_DEPTH     = 4,
    parameter int ALU_OP_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             in_instr_i,
    input  logic [XLEN-1:0]         in_pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         pc_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [1:0]              ex_op_a_sel_o,
    output logic [2:0]              ex_op_b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_a_o,
    output logic                    wb_src_sel_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic                    illegal_instr_o
);

    import riscv_decode_pkg::*;

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);

    logic [31:0]      q_instr [IQ_DEPTH];
    logic [XLEN-1:0]  q_pc    [IQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             out_valid_q;
    logic [XLEN-1:0]  pc_q;
    decode_t          dec_q;
    decode_t          head_dec;

    logic push, pop;

    // Readiness depends only on occupancy, so a full queue never accepts even
    // when the head is popped in the same cycle.
    assign in_ready_o = (count_q != CNT_W'(IQ_DEPTH));
    assign push       = in_valid_i && in_ready_o && !flush_i;
    assign pop        = (count_q != '0) && (!out_valid_q || out_ready_i) && !flush_i;

    riscv_decode_comb u_decode_comb (
        .instr (q_instr[rd_ptr_q]),
        .dec   (head_dec)
    );

    // NOTE: queue storage has no reset; entries are only read once count_q
    // says they were written, so clearing them would add logic for nothing.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr_q] <= in_instr_i;
            q_pc[wr_ptr_q]    <= in_pc_i;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            dec_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            pc_q        <= q_pc[rd_ptr_q];
            dec_q       <= head_dec;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign pc_o            = pc_q;
    assign rs1_o           = dec_q.rs1;
    assign rs2_o           = dec_q.rs2;
    assign rd_o            = dec_q.rd;
    assign imm_o           = XLEN'(signed'(dec_q.imm));
    assign ex_op_a_sel_o   = dec_q.op_a_sel;
    assign ex_op_b_sel_o   = dec_q.op_b_sel;
    assign alu_op_o        = ALU_OP_WIDTH'(dec_q.alu_op);
    assign mem_req_o       = dec_q.mem_req;
    assign mem_we_o        = dec_q.mem_we;
    assign mem_size_o      = dec_q.mem_size;
    assign gpr_we_a_o      = dec_q.gpr_we;
    assign wb_src_sel_o    = dec_q.wb_src;
    assign branch_o        = dec_q.branch;
    assign jal_o           = dec_q.jal;
    assign jalr_o          = dec_q.jalr;
    assign illegal_instr_o = dec_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage
//   Directed self-checking bench for riscv_decode_stage (IQ_DEPTH=4).
//   Define RV_M_EXT_EN for both RTL and bench to check the M-extension build.
module tb_riscv_decode_stage;
    import riscv_decode_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_instr_i = '0;
    logic [31:0] in_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [1:0]  ex_op_a_sel_o;
    logic [2:0]  ex_op_b_sel_o;
    logic [4:0]  alu_op_o;
    logic        mem_req_o, mem_we_o;
    logic [2:0]  mem_size_o;
    logic        gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o, illegal_instr_o;

    int checks = 0;
    int errors = 0;

    riscv_decode_stage #(.XLEN(32), .IQ_DEPTH(4), .ALU_OP_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
        .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o), .alu_op_o(alu_op_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .illegal_instr_o(illegal_instr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  alu;
        logic [1:0]  opa;
        logic [2:0]  opb;
        logic [2:0]  size;
        logic [7:0]  flags; // {mem_req, mem_we, gpr_we, wb_src, branch, jal, jalr, illegal}
    } vec_t;

    function automatic logic [31:0] mk_addi(input int i);
        return (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
    endfunction

    // Presents one instruction for one edge; caller ensures in_ready_o=1.
    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid_i = 1'b1;
        in_instr_i = instr;
        in_pc_i    = pc;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
        checks++; if ({pc_o, imm_o, rd_o, gpr_we_a_o, illegal_instr_o} !== '0) begin errors++; $display("FAIL reset_outputs: pc %h imm %h rd %0d we %b ill %b expected all 0", pc_o, imm_o, rd_o, gpr_we_a_o, illegal_instr_o); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset: in_ready %b out_valid %b expected 1/0", in_ready_o, out_valid_o); end
    endtask

    task automatic test_addi;
        push(32'h0050_0093, 32'h100);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL addi_latency: out_valid %b after one edge expected 0", out_valid_o); end
        @(posedge clk_i); #1;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", out_valid_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h expected 00000100", pc_o); end
        checks++; if ({rd_o, rs1_o} !== {5'd1, 5'd0}) begin errors++; $display("FAIL addi_regs: rd %0d rs1 %0d expected 1/0", rd_o, rs1_o); end
        checks++; if (imm_o !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h expected 5", imm_o); end
        checks++; if (alu_op_o !== ALU_ADD || ex_op_a_sel_o !== 2'd0 || ex_op_b_sel_o !== 3'd1) begin errors++; $display("FAIL addi_ops: alu %0d a %0d b %0d expected 0/0/1", alu_op_o, ex_op_a_sel_o, ex_op_b_sel_o); end
        checks++; if ({gpr_we_a_o, mem_req_o, illegal_instr_o} !== 3'b100) begin errors++; $display("FAIL addi_ctrl: we/req/ill %b expected 100", {gpr_we_a_o, mem_req_o, illegal_instr_o}); end
    endtask

    task automatic test_formats;
        vec_t v [10];
        v[0] = '{32'h0040_A103, 32'h0000_0004, 1'b1, ALU_ADD, 2'd0, 3'd1, LDST_W, 8'b1011_0000}; // LW x2,4(x1)
        v[1] = '{32'h0020_A423, 32'h0000_0008, 1'b1, ALU_ADD, 2'd0, 3'd1, LDST_W, 8'b1100_0000}; // SW x2,8(x1)
        v[2] = '{32'hFE20_8EE3, 32'hFFFF_FFFC, 1'b1, ALU_EQ,  2'd0, 3'd0, 3'd0,   8'b0000_1000}; // BEQ -4
        v[3] = '{32'h0020_E863, 32'h0000_0010, 1'b1, ALU_LTU, 2'd0, 3'd0, 3'd0,   8'b0000_1000}; // BLTU +16
        v[4] = '{32'h0080_00EF, 32'h0000_0008, 1'b1, ALU_ADD, 2'd1, 3'd2, 3'd0,   8'b0010_0100}; // JAL x1,+8
        v[5] = '{32'h0002_80E7, 32'h0000_0000, 1'b1, ALU_ADD, 2'd1, 3'd2, 3'd0,   8'b0010_0010}; // JALR x1,0(x5)
        v[6] = '{32'h1234_52B7, 32'h1234_5000, 1'b1, ALU_ADD, 2'd2, 3'd1, 3'd0,   8'b0010_0000}; // LUI
        v[7] = '{32'h0000_1217, 32'h0000_1000, 1'b1, ALU_ADD, 2'd1, 3'd1, 3'd0,   8'b0010_0000}; // AUIPC
        v[8] = '{32'h4030_D093, 32'h0000_0403, 1'b1, ALU_SRA, 2'd0, 3'd1, 3'd0,   8'b0010_0000}; // SRAI x1,x1,3
        v[9] = '{32'h4020_81B3, 32'h0000_0000, 1'b0, ALU_SUB, 2'd0, 3'd0, 3'd0,   8'b0010_0000}; // SUB x3,x1,x2
        for (int i = 0; i < 10; i++) begin
            push(v[i].instr, 32'h400 + 32'(4 * i));
            @(posedge clk_i); #1;
            checks++; if (out_valid_o !== 1'b1 || alu_op_o !== v[i].alu) begin errors++; $display("FAIL fmt%0d_alu: valid %b alu %0d expected 1/%0d", i, out_valid_o, alu_op_o, v[i].alu); end
            checks++; if ({ex_op_a_sel_o, ex_op_b_sel_o} !== {v[i].opa, v[i].opb}) begin errors++; $display("FAIL fmt%0d_sel: a %0d b %0d expected %0d/%0d", i, ex_op_a_sel_o, ex_op_b_sel_o, v[i].opa, v[i].opb); end
            checks++; if ({mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o, illegal_instr_o} !== v[i].flags) begin errors++; $display("FAIL fmt%0d_flags: got %b expected %b", i, {mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o, illegal_instr_o}, v[i].flags); end
            if (v[i].chk_imm) begin
                checks++; if (imm_o !== v[i].imm) begin errors++; $display("FAIL fmt%0d_imm: got %h expected %h", i, imm_o, v[i].imm); end
            end
            if (v[i].flags[7]) begin
                checks++; if (mem_size_o !== v[i].size) begin errors++; $display("FAIL fmt%0d_size: got %0d expected %0d", i, mem_size_o, v[i].size); end
            end
        end
    endtask

    task automatic test_illegal;
        logic [31:0] instr [12];
        logic        ill   [12];
        instr = '{32'h0000_0000, 32'h0000_707F, 32'h0000_B003, 32'h0020_B423, 32'h0020_A063, 32'h0000_90E7,
                  32'h4020_C033, 32'h4000_9093, 32'h0020_0073, 32'h0050_0092, 32'h0000_0073, 32'h0010_0073};
        ill   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            push(instr[i], 32'h800 + 32'(4 * i));
            @(posedge clk_i); #1;
            checks++; if (out_valid_o !== 1'b1 || illegal_instr_o !== ill[i]) begin errors++; $display("FAIL ill%0d_flag (%h): valid %b illegal %b expected 1/%b", i, instr[i], out_valid_o, illegal_instr_o, ill[i]); end
            checks++; if ({mem_req_o, mem_we_o, gpr_we_a_o, branch_o, jal_o, jalr_o} !== 6'b0) begin errors++; $display("FAIL ill%0d_effects (%h): got %b expected 000000", i, instr[i], {mem_req_o, mem_we_o, gpr_we_a_o, branch_o, jal_o, jalr_o}); end
        end
        // FENCE is a legal no-op
        push(32'h0FF0_000F, 32'h900);
        @(posedge clk_i); #1;
        checks++; if ({out_valid_o, illegal_instr_o, gpr_we_a_o, mem_req_o} !== 4'b1000) begin errors++; $display("FAIL fence: valid/ill/we/req %b expected 1000", {out_valid_o, illegal_instr_o, gpr_we_a_o, mem_req_o}); end
    endtask

    task automatic test_back_to_back;
        int  accepted = 0;
        int  got = 0;
        bit  stalled = 0;
        bit  drop;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        for (int cyc = 0; cyc < 12 && !stalled; cyc++) begin
            in_valid_i = 1'b1;
            in_instr_i = mk_addi(accepted);
            in_pc_i    = 32'h200 + 32'(4 * accepted);
            if (!in_ready_o) stalled = 1;
            else begin
                @(posedge clk_i); #1;
                accepted++;
            end
        end
        // One in the output register plus IQ_DEPTH queued.
        checks++; if (!stalled || accepted != 5) begin errors++; $display("FAIL fill: stalled %0d accepted %0d expected 1/5", stalled, accepted); end
        for (int c = 0; c < 3; c++) begin
            checks++; if ({out_valid_o, in_ready_o, rd_o, pc_o} !== {1'b1, 1'b0, 5'd1, 32'h200}) begin errors++; $display("FAIL hold%0d: valid %b ready %b rd %0d pc %h expected 1/0/1/00000200", c, out_valid_o, in_ready_o, rd_o, pc_o); end
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            drop = in_valid_i && in_ready_o;
            if (out_valid_o) begin
                checks++; if (rd_o !== 5'(got + 1) || pc_o !== 32'h200 + 32'(4 * got)) begin errors++; $display("FAIL order%0d: rd %0d pc %h expected %0d/%h", got, rd_o, pc_o, got + 1, 32'h200 + 32'(4 * got)); end
                got++;
            end
            @(posedge clk_i); #1;
            if (drop) in_valid_i = 1'b0;
        end
        checks++; if (got != 6 || out_valid_o !== 1'b0) begin errors++; $display("FAIL drain: received %0d valid %b expected 6/0", got, out_valid_o); end
    endtask

    task automatic test_flush;
        bit seen = 0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h0000_0513 | (32'(i) << 20), 32'hA00 + 32'(4 * i));
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_instr_i = 32'h0140_0A13; // ADDI x20,x0,20
        in_pc_i    = 32'hB00;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_now: valid %b ready %b expected 0/1", out_valid_o, in_ready_o); end
        out_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid_o) seen = 1;
            @(posedge clk_i); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_residue: out_valid seen %b expected 0", seen); end
        push(32'h0070_0393, 32'hC00); // ADDI x7,x0,7
        @(posedge clk_i); #1;
        checks++; if ({out_valid_o, rd_o, pc_o} !== {1'b1, 5'd7, 32'hC00}) begin errors++; $display("FAIL flush_recover: valid %b rd %0d pc %h expected 1/7/00000c00", out_valid_o, rd_o, pc_o); end
    endtask

    task automatic test_m_ext;
        push(32'h0220_8033, 32'hD00); // MUL x0,x1,x2
        @(posedge clk_i); #1;
`ifdef RV_M_EXT_EN
        checks++; if ({out_valid_o, illegal_instr_o, gpr_we_a_o} !== 3'b101 || alu_op_o !== ALU_MUL) begin errors++; $display("FAIL mul: valid/ill/we %b alu %0d expected 101/%0d", {out_valid_o, illegal_instr_o, gpr_we_a_o}, alu_op_o, ALU_MUL); end
`else
        checks++; if ({out_valid_o, illegal_instr_o, gpr_we_a_o} !== 3'b110) begin errors++; $display("FAIL mul: valid/ill/we %b expected 110", {out_valid_o, illegal_instr_o, gpr_we_a_o}); end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_m_ext();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
